// File: rtl/gascon_pkg.sv
// Gascon round primitives: round constant, S-box layer, interleaved-rotation linear layer.
package gascon_pkg;

  localparam int MAX_WORDS = 9;

  typedef logic [MAX_WORDS-1:0][63:0] words_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  localparam int ROT5_A [5] = '{19, 61, 1, 10, 7};
  localparam int ROT5_B [5] = '{28, 38, 6, 17, 40};
  localparam int ROT9_A [9] = '{19, 61, 1, 10, 7, 31, 53, 9, 43};
  localparam int ROT9_B [9] = '{28, 38, 6, 17, 40, 26, 58, 46, 50};

  function automatic int mid(input int nw);
    return (nw - 1) / 2;
  endfunction

  function automatic logic [7:0] rc(input logic [3:0] r);
    return {4'hF - r, r};
  endfunction

  function automatic int rot_amt(input int nw, input int i, input bit second);
    if (nw == 5) return second ? ROT5_B[i] : ROT5_A[i];
    return second ? ROT9_B[i] : ROT9_A[i];
  endfunction

  function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Words are bit-interleaved: even bits in [31:0], odd bits in [63:32].
  function automatic logic [63:0] irotr64(input logic [63:0] x, input int s);
    if (s % 2 == 0)
      return {rotr32(x[63:32], s / 2), rotr32(x[31:0], s / 2)};
    return {rotr32(x[31:0], (s + 1) / 2), rotr32(x[63:32], (s - 1) / 2)};
  endfunction

  function automatic words_t sbox(input words_t x_in, input int nw);
    words_t x;
    words_t t;
    x = x_in;
    t = '0;
    for (int i = 0; i < MAX_WORDS; i += 2)
      if (i < nw) x[i] = x[i] ^ x[(i + nw - 1) % nw];
    for (int i = 0; i < MAX_WORDS; i++)
      if (i < nw) t[i] = ~x[i] & x[(i + 1) % nw];
    for (int i = 0; i < MAX_WORDS; i++)
      if (i < nw) x[i] = x[i] ^ t[(i + 1) % nw];
    for (int i = 1; i < MAX_WORDS; i += 2)
      if (i < nw) x[i] = x[i] ^ x[i - 1];
    x[mid(nw)] = ~x[mid(nw)];
    return x;
  endfunction

  function automatic words_t linear(input words_t x_in, input int nw);
    words_t x;
    x = x_in;
    for (int i = 0; i < MAX_WORDS; i++)
      if (i < nw)
        x[i] = x[i] ^ irotr64(x[i], rot_amt(nw, i, 1'b0)) ^ irotr64(x[i], rot_amt(nw, i, 1'b1));
    return x;
  endfunction

endpackage

// File: rtl/gascon_round.sv
// One combinational Gascon round; en=0 passes the state through untouched.
module gascon_round
  import gascon_pkg::*;
#(
  parameter int CWORDS64 = 5
) (
  input  logic [64*CWORDS64-1:0] s_in,
  input  logic [3:0]             rnd,
  input  logic                   en,
  output logic [64*CWORDS64-1:0] s_out
);

  localparam int MIDW = mid(CWORDS64);

  words_t w_in;
  words_t w_out;

  always_comb begin
    w_in = '0;
    for (int i = 0; i < CWORDS64; i++) w_in[i] = s_in[64*i +: 64];
    w_in[MIDW] = w_in[MIDW] ^ {56'b0, rc(rnd)};
    w_out = linear(sbox(w_in, CWORDS64), CWORDS64);
    s_out = s_in;
    if (en)
      for (int i = 0; i < CWORDS64; i++) s_out[64*i +: 64] = w_out[i];
  end

endmodule

// File: rtl/gascon_permutation.sv
// Iterative Gascon permutation: UNROLL chained rounds per clock, valid/ready on both sides.
module gascon_permutation
  import gascon_pkg::*;
#(
  parameter int CWORDS64   = 5,
  parameter int ROUNDS_MAX = 12,
  parameter int UNROLL     = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [64*CWORDS64-1:0] in_state,
  input  logic [3:0]             first_round,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [64*CWORDS64-1:0] out_state,
  output logic                   busy
);

  localparam int CWIDTH = 64 * CWORDS64;

  fsm_t              fsm;
  logic [CWIDTH-1:0] state;
  logic [4:0]        rnd;
  logic [4:0]        rnd_next;

  assign rnd_next = rnd + 5'(UNROLL);

  // Round chain; stages past the last round become identity.
  for (genvar k = 0; k < UNROLL; k++) begin : g_stage
    logic [CWIDTH-1:0] s_in;
    logic [CWIDTH-1:0] s_out;
    logic [4:0]        rk;
    assign rk = rnd + 5'(k);
    if (k == 0) begin : g_first
      assign s_in = state;
    end else begin : g_next
      assign s_in = g_stage[k-1].s_out;
    end
    gascon_round #(.CWORDS64(CWORDS64)) u_round (
      .s_in  (s_in),
      .rnd   (rk[3:0]),
      .en    (rk < 5'(ROUNDS_MAX)),
      .s_out (s_out)
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm   <= IDLE;
      state <= '0;
      rnd   <= '0;
    end else begin
      case (fsm)
        IDLE: if (in_valid) begin
          state <= in_state;
          rnd   <= {1'b0, first_round};
          fsm   <= ({1'b0, first_round} < 5'(ROUNDS_MAX)) ? RUN : DONE;
        end
        RUN: begin
          state <= g_stage[UNROLL-1].s_out;
          rnd   <= rnd_next;
          if (rnd_next >= 5'(ROUNDS_MAX)) fsm <= DONE;
        end
        DONE: if (out_ready) fsm <= IDLE;
        default: fsm <= IDLE;
      endcase
    end
  end

  assign in_ready  = (fsm == IDLE);
  assign out_valid = (fsm == DONE);
  assign busy      = (fsm != IDLE);
  assign out_state = (fsm == DONE) ? state : '0;

endmodule
